// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the single-clock FIFO family.
//   fifo_clog2      - ceil(log2(n)), used to size addresses from a depth
//   fifo_depth      - DEPTH derivation from ADDR_WIDTH (2**ADDR_WIDTH)
//   fifo_params_ok  - legality of the almost-full / almost-empty levels
//   fifo_flags_t    - grouped occupancy flags decoded from the fill count
package fifo_pkg;

  function automatic int fifo_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // AFULL_LVL in 1..DEPTH, AEMPTY_LVL in 0..DEPTH-1, and AEMPTY_LVL < AFULL_LVL.
  function automatic bit fifo_params_ok(input int addr_width, input int afull_lvl,
                                        input int aempty_lvl);
    int depth;
    depth = fifo_depth(addr_width);
    return (afull_lvl >= 1) && (afull_lvl <= depth) &&
           (aempty_lvl >= 0) && (aempty_lvl <= depth - 1) &&
           (aempty_lvl < afull_lvl);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH storage array for sync_fifo_flags.
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   asynchronous read address
//   rdata  out  mem[raddr], combinational
// The array is deliberately not reset; occupancy is tracked by the pointers.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = fifo_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through.
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   W_INC      in   write request, WR_DATA sampled with it
//   WR_DATA    in   write data
//   R_INC      in   read request (FWFT: acknowledge/pop the head word)
//   CLR_ERR    in   clears OVERFLOW / UNDERFLOW (a same-cycle new error wins)
//   RD_DATA    out  read data (registered for FWFT=0, head word for FWFT=1)
//   FULL       out  COUNT == DEPTH
//   EMPTY      out  COUNT == 0
//   AFULL      out  COUNT >= AFULL_LVL
//   AEMPTY     out  COUNT <= AEMPTY_LVL
//   COUNT      out  words stored
//   OVERFLOW   out  sticky: write attempted while FULL
//   UNDERFLOW  out  sticky: read attempted while EMPTY
//
// Handshake: a write is taken on any rising edge where W_INC=1 and FULL=0, a
// read on any rising edge where R_INC=1 and EMPTY=0. Requests are not held or
// retried: a request against FULL/EMPTY is dropped and only raises the sticky
// error flag. Both may be taken in the same cycle.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_LVL  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

  if (!fifo_params_ok(ADDR_WIDTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
    $error("sync_fifo_flags: illegal AFULL_LVL/AEMPTY_LVL for this ADDR_WIDTH");
  end

  // Pointers carry one extra bit so they wrap modulo 2*DEPTH; only the low
  // ADDR_WIDTH bits address the array.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  fifo_flags_t           flags;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come only from the registered count, never from the requests.
  always_comb begin
    flags        = '0;
    flags.full   = (count_q == DEPTH_C);
    flags.empty  = (count_q == '0);
    flags.afull  = (count_q >= AFULL_C);
    flags.aempty = (count_q <= AEMPTY_C);
  end

  always_comb begin
    wr_acc = W_INC & ~flags.full;
    rd_acc = R_INC & ~flags.empty;
    // Suppress the array write in the reset cycle so a request there leaves no trace.
    mem_we = wr_acc & ~RST;

    wr_ptr_d = wr_acc ? (wr_ptr_q + ONE_C) : wr_ptr_q;
    rd_ptr_d = rd_acc ? (rd_ptr_q + ONE_C) : rd_ptr_q;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // New error event takes priority over a same-cycle clear.
    ovf_d = (W_INC & flags.full)  | (ovf_q & ~CLR_ERR);
    udf_d = (R_INC & flags.empty) | (udf_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (ADDR_WIDTH)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (WR_DATA),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; it is meaningful only while EMPTY=0.
    assign RD_DATA = mem_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_acc ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    assign RD_DATA = rd_data_q;
  end

  assign FULL      = flags.full;
  assign EMPTY     = flags.empty;
  assign AFULL     = flags.afull;
  assign AEMPTY    = flags.aempty;
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: drives one stimulus stream into a registered-read
// instance and an FWFT instance of sync_fifo_flags and checks both.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST = 1'b1;
  logic          W_INC = 1'b0;
  logic [DW-1:0] WR_DATA = '0;
  logic          R_INC = 1'b0;
  logic          CLR_ERR = 1'b0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          full0, full1, empty0, empty1, afull0, afull1, aempty0, aempty1;
  logic [AW:0]   count0, count1;
  logic          ovf0, ovf1, udf0, udf1;

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL), .FWFT(0)
  ) u_std (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA), .R_INC(R_INC),
    .CLR_ERR(CLR_ERR), .RD_DATA(rd_data0), .FULL(full0), .EMPTY(empty0),
    .AFULL(afull0), .AEMPTY(aempty0), .COUNT(count0), .OVERFLOW(ovf0),
    .UNDERFLOW(udf0)
  );

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL), .FWFT(1)
  ) u_fwft (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA), .R_INC(R_INC),
    .CLR_ERR(CLR_ERR), .RD_DATA(rd_data1), .FULL(full1), .EMPTY(empty1),
    .AFULL(afull1), .AEMPTY(aempty1), .COUNT(count1), .OVERFLOW(ovf1),
    .UNDERFLOW(udf1)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q0[$];   // words the registered-read instance must return
  logic [DW-1:0] exp_q1[$];   // words the FWFT instance must present
  int            mcount = 0;
  logic          movf = 1'b0;
  logic          mudf = 1'b0;
  logic [DW-1:0] last0 = '0;  // expected registered RD_DATA

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic [AW:0] cnt, input logic emp,
                           input logic ful, input logic af, input logic ae,
                           input logic ov, input logic ud);
    chk({tag, "_count"},     32'(cnt), 32'(mcount));
    chk({tag, "_empty"},     32'(emp), 32'(mcount == 0));
    chk({tag, "_full"},      32'(ful), 32'(mcount == DEPTH));
    chk({tag, "_afull"},     32'(af),  32'(mcount >= AFL));
    chk({tag, "_aempty"},    32'(ae),  32'(mcount <= AEL));
    chk({tag, "_overflow"},  32'(ov),  32'(movf));
    chk({tag, "_underflow"}, 32'(ud),  32'(mudf));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: checks the FWFT head, drives one cycle of
  // requests, updates the expectation, then checks both instances.
  task automatic step(input logic rst, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic clr);
    logic w_acc;
    logic r_acc;
    logic [DW-1:0] tmp;
    if (mcount != 0) chk("fwft_head", 32'(rd_data1), 32'(exp_q1[0]));
    RST = rst; W_INC = w; WR_DATA = d; R_INC = r; CLR_ERR = clr;
    w_acc = !rst && w && (mcount != DEPTH);
    r_acc = !rst && r && (mcount != 0);
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      mcount = 0;
      movf   = 1'b0;
      mudf   = 1'b0;
      last0  = '0;
    end else begin
      movf = (w && mcount == DEPTH) || (movf && !clr);
      mudf = (r && mcount == 0)     || (mudf && !clr);
      if (r_acc) begin
        last0 = exp_q0.pop_front();
        tmp   = exp_q1.pop_front();
      end
      if (w_acc) begin
        exp_q0.push_back(d);
        exp_q1.push_back(d);
      end
      mcount = mcount + int'(w_acc) - int'(r_acc);
    end
    @(posedge CLK);
    @(negedge CLK);
    check_dut("std",  count0, empty0, full0, afull0, aempty0, ovf0, udf0);
    check_dut("fwft", count1, empty1, full1, afull1, aempty1, ovf1, udf1);
    chk("std_rd_data", 32'(rd_data0), 32'(last0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          clr;
    int            exp_count;
    logic          exp_ovf;
    logic          exp_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic w, input logic [DW-1:0] d,
                              input logic r, input logic clr, input int c,
                              input logic o, input logic u);
    vec_t v;
    v.rst = rst; v.w = w; v.d = d; v.r = r; v.clr = clr;
    v.exp_count = c; v.exp_ovf = o; v.exp_udf = u;
    return v;
  endfunction

  initial begin
    // Reset, fill 0x01..0x10, overflow with 0xAA, clear, drain, read+write at empty.
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(0, 1, 8'(i), 0, 0, i, 0, 0));
    vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 16, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 16, 0, 0));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(0, 0, 8'h00, 1, 0, 16 - k, 0, 0));
    vecs.push_back(mk(0, 1, 8'h5A, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].clr);
      chk("tbl_count_std",  32'(count0), 32'(vecs[i].exp_count));
      chk("tbl_count_fwft", 32'(count1), 32'(vecs[i].exp_count));
      chk("tbl_ovf_std",    32'(ovf0),   32'(vecs[i].exp_ovf));
      chk("tbl_ovf_fwft",   32'(ovf1),   32'(vecs[i].exp_ovf));
      chk("tbl_udf_std",    32'(udf0),   32'(vecs[i].exp_udf));
      chk("tbl_udf_fwft",   32'(udf1),   32'(vecs[i].exp_udf));
    end

    // Clear and a new underflow in the same cycle: the flag stays set.
    step(0, 0, 8'h00, 1, 1);
    chk("set_wins_udf", 32'(udf0), 32'd1);
    step(0, 0, 8'h00, 0, 1);

    // Hold COUNT=8 while streaming one write and one read per cycle; 78 total
    // writes wrap the 5-bit pointers twice.
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 70; i++) begin
      step(0, 1, 8'(i), 1, 0);
      chk("stream_count", 32'(count0), 32'd8);
    end

    // Full with both requests: read taken, write dropped, overflow raised.
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
    chk("full_before_rw", 32'(full1), 32'd1);
    step(0, 1, 8'hEE, 1, 0);
    chk("full_rw_count", 32'(count0), 32'd15);
    chk("full_rw_ovf",   32'(ovf1),   32'd1);
    step(0, 0, 8'h00, 0, 1);

    // Reset with COUNT=9 and requests present: everything discarded.
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);
    chk("pre_reset_count", 32'(count0), 32'd9);
    step(1, 1, 8'h77, 1, 0);
    chk("post_reset_count", 32'(count1), 32'd0);
    chk("post_reset_empty", 32'(empty0), 32'd1);
    step(0, 1, 8'h3C, 0, 0);
    chk("fwft_3c", 32'(rd_data1), 32'h3C);
    step(0, 0, 8'h00, 1, 0);
    chk("std_3c", 32'(rd_data0), 32'h3C);

    // Random traffic with occasional error clears.
    for (int i = 0; i < 300; i++) begin
      step(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
